// File: rtl/corescore_gatemate_pkg.sv
// Shared constants, state encoding and message helpers for the CoreScore GateMate top.
package corescore_gatemate_pkg;

   localparam int MSG_LEN = 8;

   localparam logic [7:0] CHAR_C     = 8'h43;
   localparam logic [7:0] CHAR_O     = 8'h6F;
   localparam logic [7:0] CHAR_R     = 8'h72;
   localparam logic [7:0] CHAR_E     = 8'h65;
   localparam logic [7:0] CHAR_SPACE = 8'h20;
   localparam logic [7:0] CHAR_ZERO  = 8'h30;
   localparam logic [7:0] CHAR_LF    = 8'h0A;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_e;

   // Round-to-nearest so odd clock/baud ratios land on the closest divisor.
   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

   function automatic logic [7:0] msg_byte(input int core_idx, input int byte_idx);
      logic [7:0] ch;
      case (byte_idx)
         0:       ch = CHAR_C;
         1:       ch = CHAR_O;
         2:       ch = CHAR_R;
         3:       ch = CHAR_E;
         4:       ch = CHAR_SPACE;
         5:       ch = CHAR_ZERO + 8'(core_idx / 10);
         6:       ch = CHAR_ZERO + 8'(core_idx % 10);
         default: ch = CHAR_LF;
      endcase
      return ch;
   endfunction

endpackage

// File: rtl/corescore_gatemate_if.sv
// Byte-wide valid/ready channel between the message arbiter and the UART transmitter.
interface corescore_gatemate_if;

   logic       valid;
   logic       ready;
   logic [7:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/corescore_gatemate_uart_tx.sv
// 8N1 UART transmitter with a valid/ready byte input and a registered serial output.
module corescore_uart_tx
   import corescore_gatemate_pkg::*;
#(
   parameter int CLKS_PER_BIT = 174
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   corescore_gatemate_if.slave   bus,
   output logic                  tx_o
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   // The single idle cycle spent accepting the next byte completes the stop bit.
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CLKS_PER_BIT - 2);

   tx_state_e        state_q, state_d;
   logic [CNT_W-1:0] baud_q, baud_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= TX_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      unique case (state_q)
         TX_IDLE: begin
            baud_d = '0;
            if (bus.valid) begin
               state_d = TX_START;
               shift_d = bus.data;
            end
         end
         TX_START: begin
            if (baud_q == BIT_LAST) begin
               state_d = TX_DATA;
               baud_d  = '0;
               bit_d   = '0;
            end
         end
         TX_DATA: begin
            if (baud_q == BIT_LAST) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  state_d = TX_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         TX_STOP: begin
            if (baud_q == STOP_LAST) begin
               state_d = TX_IDLE;
               baud_d  = '0;
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

   // Line level is derived from the next state so the output flop changes with the state flop.
   always_comb begin
      bus.ready = (state_q == TX_IDLE);
      unique case (state_d)
         TX_START: tx_d = 1'b0;
         TX_DATA:  tx_d = shift_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   assign tx_o = tx_q;

endmodule

// File: rtl/corescore_gatemate_top.sv
// CoreScore top: NUM_CORES greeting sources serialised onto one UART line, once per reset.
module corescore_gatemate_top
   import corescore_gatemate_pkg::*;
#(
   parameter int NUM_CORES   = 4,
   parameter int CLK_FREQ_HZ = 10_000_000,
   parameter int BAUD_RATE   = 57600
) (
   input  logic i_clk,
   input  logic i_rstn,
   output logic o_uart_tx
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);

   logic [1:0]           rstSync_q;
   logic                 rstInt_n;
   logic [NUM_CORES-1:0] pending_q, pending_d;
   logic [2:0]           byteIdx_q, byteIdx_d;
   logic [6:0]           grantIdx;

   corescore_gatemate_if txBus ();

   // Assertion is asynchronous; release reaches the rest of the design two edges later.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         rstSync_q <= '0;
      end else begin
         rstSync_q <= {rstSync_q[0], 1'b1};
      end
   end

   assign rstInt_n = rstSync_q[1];

   always_ff @(posedge i_clk or negedge rstInt_n) begin
      if (!rstInt_n) begin
         pending_q <= '1;
         byteIdx_q <= '0;
      end else begin
         pending_q <= pending_d;
         byteIdx_q <= byteIdx_d;
      end
   end

   always_comb begin
      grantIdx = '0;
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
         if (pending_q[k]) begin
            grantIdx = 7'(k);
         end
      end
   end

   // The granted core is always the lowest set bit, so finishing it just clears that bit.
   always_comb begin
      pending_d = pending_q;
      byteIdx_d = byteIdx_q;
      if (txBus.valid && txBus.ready) begin
         byteIdx_d = byteIdx_q + 3'd1;
         if (byteIdx_q == 3'(MSG_LEN - 1)) begin
            pending_d = pending_q & (pending_q - NUM_CORES'(1));
         end
      end
   end

   assign txBus.valid = |pending_q;
   assign txBus.data  = msg_byte(int'(grantIdx), int'(byteIdx_q));

   corescore_uart_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) uartTx (
      .clk_i  (i_clk),
      .rst_ni (rstInt_n),
      .bus    (txBus),
      .tx_o   (o_uart_tx)
   );

endmodule

// File: tb/tb_corescore_gatemate_top.sv
// Directed bench: decodes the UART stream of a 4-core and a fast 12-core instance.
`timescale 1ns/1ps
module tb_corescore_gatemate_top;

   localparam int CPB_A = 174;
   localparam int CPB_B = 4;

   logic clk = 1'b0;
   logic rstnA;
   logic rstnB;
   logic txA;
   logic txB;

   int   assertCount = 0;
   int   failCount   = 0;
   int   cycle       = 0;
   logic recordEdges = 1'b0;
   logic prevA       = 1'b1;
   int   edgeQ[$];
   int   startCyc[32];

   string expA = "Core 00\nCore 01\nCore 02\nCore 03\n";
   string expB = {"Core 00\nCore 01\nCore 02\nCore 03\nCore 04\nCore 05\n",
                  "Core 06\nCore 07\nCore 08\nCore 09\nCore 10\nCore 11\n"};

   corescore_gatemate_if rxBus ();

   corescore_gatemate_top #(
      .NUM_CORES(4)
   ) dutA (
      .i_clk     (clk),
      .i_rstn    (rstnA),
      .o_uart_tx (txA)
   );

   corescore_gatemate_top #(
      .NUM_CORES   (12),
      .CLK_FREQ_HZ (230400),
      .BAUD_RATE   (57600)
   ) dutB (
      .i_clk     (clk),
      .i_rstn    (rstnB),
      .o_uart_tx (txB)
   );

   always #50 clk = ~clk;

   always @(posedge clk) cycle++;

   always @(negedge clk) begin
      if (recordEdges && txA !== prevA) edgeQ.push_back(cycle);
      prevA = txA;
   end

   function automatic logic lineOf(input int sel);
      return (sel != 0) ? txB : txA;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic a, input logic b);
      rstnA = a;
      rstnB = b;
   endtask

   task automatic receiveByte(input int sel, input bit inStart, output logic [7:0] b,
                              output bit ok, output int startAt);
      int cpb;
      int waited;
      logic [7:0] d;
      cpb = (sel != 0) ? CPB_B : CPB_A;
      ok = 1'b1;
      b = '0;
      d = '0;
      startAt = 0;
      if (!inStart) begin
         waited = 0;
         do begin
            @(negedge clk);
            waited++;
         end while (lineOf(sel) !== 1'b0 && waited < 3 * cpb);
         if (lineOf(sel) !== 1'b0) begin
            ok = 1'b0;
            return;
         end
      end else begin
         @(negedge clk);
      end
      startAt = cycle;
      repeat (cpb / 2) @(negedge clk);
      if (lineOf(sel) !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (cpb) @(negedge clk);
         d[i] = lineOf(sel);
      end
      repeat (cpb) @(negedge clk);
      if (lineOf(sel) !== 1'b1) ok = 1'b0;
      b = d;
      rxBus.data  = d;
      rxBus.valid = 1'b1;
   endtask

   task automatic releaseAndFindStart(input int sel, output int firstLow);
      firstLow = 0;
      @(negedge clk);
      if (sel != 0) applyStimulus(rstnA, 1'b1);
      else          applyStimulus(1'b1, rstnB);
      for (int i = 1; i <= 4 && firstLow == 0; i++) begin
         @(posedge clk);
         #1;
         if (lineOf(sel) === 1'b0) firstLow = i;
      end
   endtask

   initial begin
      logic [7:0] b;
      bit         ok;
      int         st;
      int         firstLow;
      int         lowA;
      int         lowB;
      int         waited;

      rxBus.valid = 1'b0;
      rxBus.data  = '0;
      rxBus.ready = 1'b1;

      applyStimulus(1'b0, 1'b0);
      lowA = 0;
      lowB = 0;
      repeat (20) begin
         @(negedge clk);
         if (txA !== 1'b1) lowA++;
         if (txB !== 1'b1) lowB++;
      end
      checkOutput("reset_hold_lowA", lowA, 0);
      checkOutput("reset_hold_lowB", lowB, 0);

      releaseAndFindStart(1, firstLow);
      checkOutput("B_first_start", (firstLow >= 1 && firstLow <= 4), 1);
      for (int i = 0; i < 96; i++) begin
         receiveByte(1, (i == 0 && firstLow != 0), b, ok, st);
         checkOutput($sformatf("B_byte%0d", i), {ok, b}, {1'b1, expB[i]});
      end
      lowB = 0;
      repeat (200) begin
         @(negedge clk);
         if (txB !== 1'b1) lowB++;
      end
      checkOutput("B_idle_lows", lowB, 0);

      releaseAndFindStart(0, firstLow);
      checkOutput("A_first_start", (firstLow >= 1 && firstLow <= 4), 1);
      for (int i = 0; i < 10; i++) begin
         receiveByte(0, (i == 0 && firstLow != 0), b, ok, st);
         checkOutput($sformatf("A_run1_byte%0d", i), {ok, b}, {1'b1, expA[i]});
      end

      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (txA !== 1'b0 && waited < 3 * CPB_A);
      repeat (CPB_A + CPB_A / 2) @(negedge clk);
      checkOutput("A_byte10_bit0_low", txA, 0);
      #10;
      applyStimulus(1'b0, 1'b1);
      #1;
      checkOutput("A_async_reset_tx", txA, 1);
      lowA = 0;
      repeat (10) begin
         @(negedge clk);
         if (txA !== 1'b1) lowA++;
      end
      checkOutput("A_midreset_hold_lows", lowA, 0);

      edgeQ.delete();
      recordEdges = 1'b1;
      releaseAndFindStart(0, firstLow);
      checkOutput("A_restart_first_start", (firstLow >= 1 && firstLow <= 4), 1);
      for (int i = 0; i < 32; i++) begin
         receiveByte(0, (i == 0 && firstLow != 0), b, ok, st);
         startCyc[i] = st;
         checkOutput($sformatf("A_run2_byte%0d", i), {ok, b}, {1'b1, expA[i]});
      end
      for (int i = 1; i < 32; i++) begin
         checkOutput($sformatf("A_start_spacing%0d", i), startCyc[i] - startCyc[i-1], 1740);
      end

      checkOutput("A_edge_count", (edgeQ.size() >= 7), 1);
      if (edgeQ.size() >= 7) begin
         checkOutput("A_start_bit_len", edgeQ[1] - edgeQ[0], 174);
         checkOutput("A_stop_bit_len", edgeQ[6] - edgeQ[5], 174);
      end

      lowA = 0;
      repeat (2000) begin
         @(negedge clk);
         if (txA !== 1'b1) lowA++;
      end
      checkOutput("A_idle_lows", lowA, 0);

      $display("[TB] directed sequence complete");
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
